// File: rtl/prg_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : prg_mem_arb
// Purpose  : Arbitrates a single byte-wide PRG memory between cartridge CPU
//            cycles (qualified by the asynchronous M2 clock) and MCU DMA
//            requests. CPU has priority; a running access is never aborted
//            except by reset. Every access lasts ACC_CYC clocks followed by
//            one recovery clock with all strobes low.
// Ports    : clk, rst_n                 clock, async active-low reset
//            m2, cpu_req                cartridge M2 and PRG-select qualifier
//            cpu_addr/we/wdat, cpu_rdat CPU access attributes and read data
//            cpu_ovf                    sticky lost-CPU-request flag
//            dma_req/addr/we/wdat       DMA request (level) and attributes
//            dma_ack, dma_rdat          DMA completion pulse and read data
//            mem_addr/dato/dati         memory address and data buses
//            mem_ce/oe/we               registered active-high strobes
// Revision : 1.0 - initial release
// ============================================================================
module prg_mem_arb #(
    parameter int ACC_CYC = 4,
    parameter int ADDR_W  = 23
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m2,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic [7:0]        cpu_wdat,
    output logic [7:0]        cpu_rdat,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic              dma_we,
    input  logic [7:0]        dma_wdat,
    output logic              dma_ack,
    output logic [7:0]        dma_rdat,
    output logic              cpu_ovf,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_dato,
    input  logic [7:0]        mem_dati,
    output logic              mem_ce,
    output logic              mem_oe,
    output logic              mem_we
);

    localparam int              CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ACC_CYC);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CPU   = 2'd1,
        ST_DMA   = 2'd2,
        ST_RECOV = 2'd3
    } state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;

    logic               m2_s1, m2_s2, m2_prev;
    logic               m2_rise, new_req;

    logic               cpu_pend;
    logic [ADDR_W-1:0]  cpu_addr_l;
    logic               cpu_we_l;
    logic [7:0]         cpu_wdat_l;

    logic               acc_we;
    logic               we_sel;
    logic               grant_cpu, grant_dma, last_cyc;
    logic               ce_nx, oe_nx, we_nx;

    assign m2_rise = m2_s2 & ~m2_prev;
    assign new_req = m2_rise & cpu_req;

    // ------------------------------------------------------------------------
    // Next-state, grant and strobe decode
    // ------------------------------------------------------------------------
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        grant_cpu = 1'b0;
        grant_dma = 1'b0;
        last_cyc  = 1'b0;
        ce_nx     = 1'b0;
        oe_nx     = 1'b0;
        we_nx     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (cpu_pend) begin
                    grant_cpu = 1'b1;
                    state_nx  = ST_CPU;
                    cnt_nx    = CNT_W'(1);
                end else if (dma_req) begin
                    grant_dma = 1'b1;
                    state_nx  = ST_DMA;
                    cnt_nx    = CNT_W'(1);
                end
            end
            ST_CPU, ST_DMA: begin
                if (cnt == LAST) begin
                    last_cyc = 1'b1;
                    state_nx = ST_RECOV;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            ST_RECOV: state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase

        // Direction of the access that will be running next cycle: freshly
        // granted attributes take effect immediately, otherwise the latched one.
        if (grant_cpu)
            we_sel = cpu_we_l;
        else if (grant_dma)
            we_sel = dma_we;
        else
            we_sel = acc_we;

        // Strobes are registered, so they are decoded from the next state and
        // next access-cycle number. Writes get one cycle of setup and hold.
        if (state_nx == ST_CPU || state_nx == ST_DMA) begin
            ce_nx = 1'b1;
            oe_nx = ~we_sel;
            we_nx = we_sel && (cnt_nx >= CNT_W'(2)) && (cnt_nx <= LAST - CNT_W'(1));
        end
    end

    // ------------------------------------------------------------------------
    // State register, access datapath and outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            acc_we   <= 1'b0;
            mem_addr <= '0;
            mem_dato <= '0;
            mem_ce   <= 1'b0;
            mem_oe   <= 1'b0;
            mem_we   <= 1'b0;
            dma_ack  <= 1'b0;
            cpu_rdat <= '0;
            dma_rdat <= '0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            mem_ce <= ce_nx;
            mem_oe <= oe_nx;
            mem_we <= we_nx;

            if (grant_cpu) begin
                acc_we   <= cpu_we_l;
                mem_addr <= cpu_addr_l;
                mem_dato <= cpu_wdat_l;
            end else if (grant_dma) begin
                acc_we   <= dma_we;
                mem_addr <= dma_addr;
                mem_dato <= dma_wdat;
            end

            if (last_cyc && !acc_we) begin
                if (state == ST_CPU)
                    cpu_rdat <= mem_dati;
                else
                    dma_rdat <= mem_dati;
            end

            dma_ack <= last_cyc && (state == ST_DMA);
        end
    end

    // ------------------------------------------------------------------------
    // M2 synchronizer and pending CPU request
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m2_s1      <= 1'b0;
            m2_s2      <= 1'b0;
            m2_prev    <= 1'b0;
            cpu_pend   <= 1'b0;
            cpu_ovf    <= 1'b0;
            cpu_addr_l <= '0;
            cpu_we_l   <= 1'b0;
            cpu_wdat_l <= '0;
        end else begin
            m2_s1   <= m2;
            m2_s2   <= m2_s1;
            m2_prev <= m2_s2;

            if (new_req) begin
                // A request still waiting (not granted this cycle) is lost
                // and replaced by the newer one.
                if (cpu_pend && !grant_cpu)
                    cpu_ovf <= 1'b1;
                cpu_pend   <= 1'b1;
                cpu_addr_l <= cpu_addr;
                cpu_we_l   <= cpu_we;
                cpu_wdat_l <= cpu_wdat;
            end else if (grant_cpu) begin
                cpu_pend <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prg_mem_arb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_prg_mem_arb
// Purpose  : Self-checking bench for prg_mem_arb. A schedule-based model
//            predicts every output each cycle; directed scenarios add
//            hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prg_mem_arb;

    localparam int A  = 4;
    localparam int AW = 23;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m2 = 1'b0;
    logic          cpu_req = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic          cpu_we = 1'b0;
    logic [7:0]    cpu_wdat = '0;
    logic          dma_req = 1'b0;
    logic [AW-1:0] dma_addr = '0;
    logic          dma_we = 1'b0;
    logic [7:0]    dma_wdat = '0;
    logic [7:0]    cpu_rdat, dma_rdat, mem_dato, mem_dati;
    logic          dma_ack, cpu_ovf, mem_ce, mem_oe, mem_we;
    logic [AW-1:0] mem_addr;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    function automatic logic [7:0] hashf(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Memory content is a fixed function of the address.
    assign mem_dati = hashf(mem_addr);

    prg_mem_arb #(.ACC_CYC(A), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .m2(m2), .cpu_req(cpu_req),
        .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdat(cpu_wdat),
        .cpu_rdat(cpu_rdat), .dma_req(dma_req), .dma_addr(dma_addr),
        .dma_we(dma_we), .dma_wdat(dma_wdat), .dma_ack(dma_ack),
        .dma_rdat(dma_rdat), .cpu_ovf(cpu_ovf), .mem_addr(mem_addr),
        .mem_dato(mem_dato), .mem_dati(mem_dati), .mem_ce(mem_ce),
        .mem_oe(mem_oe), .mem_we(mem_we)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Model: each access is a time slot [start, start+A-1], recovery at
    // start+A, and the arbiter is free again from start+A+1.
    // ------------------------------------------------------------------------
    int            k, free_at, acc_start, pos;
    logic          h0, h1, h2, rise, idle, gcpu, gdma;
    logic          m_pend, m_pwe;
    logic [AW-1:0] m_paddr, acc_addr;
    logic [7:0]    m_pwdat, acc_wdat;
    logic          acc_we, acc_dma;
    logic          exp_ce, exp_oe, exp_we, exp_ack, exp_ovf;
    logic [AW-1:0] exp_addr;
    logic [7:0]    exp_dato, exp_cpu_rdat, exp_dma_rdat;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k = 0; free_at = 0; acc_start = -100;
            {h0, h1, h2} = 3'b000;
            m_pend = 0; m_pwe = 0; m_paddr = '0; m_pwdat = '0;
            acc_addr = '0; acc_wdat = '0; acc_we = 0; acc_dma = 0;
            {exp_ce, exp_oe, exp_we, exp_ack, exp_ovf} = 5'b0;
            exp_addr = '0; exp_dato = '0; exp_cpu_rdat = '0; exp_dma_rdat = '0;
        end else begin
            rise = h1 & ~h2;
            idle = (k >= free_at);
            gcpu = idle && m_pend;
            gdma = idle && !m_pend && dma_req;
            exp_ack = 1'b0;
            if (k == acc_start + A - 1) begin
                if (!acc_we) begin
                    if (acc_dma) exp_dma_rdat = hashf(acc_addr);
                    else         exp_cpu_rdat = hashf(acc_addr);
                end
                exp_ack = acc_dma;
            end
            if (gcpu) begin
                acc_addr = m_paddr; acc_we = m_pwe; acc_wdat = m_pwdat; acc_dma = 0;
                acc_start = k + 1; free_at = k + A + 2;
            end else if (gdma) begin
                acc_addr = dma_addr; acc_we = dma_we; acc_wdat = dma_wdat; acc_dma = 1;
                acc_start = k + 1; free_at = k + A + 2;
            end
            if (rise && cpu_req) begin
                if (m_pend && !gcpu) exp_ovf = 1'b1;
                m_pend = 1; m_paddr = cpu_addr; m_pwe = cpu_we; m_pwdat = cpu_wdat;
            end else if (gcpu) begin
                m_pend = 0;
            end
            {h0, h1, h2} = {m2, h0, h1};
            k++;
            pos = k - acc_start + 1;
            exp_ce   = (pos >= 1) && (pos <= A);
            exp_oe   = exp_ce && !acc_we;
            exp_we   = exp_ce && acc_we && (pos >= 2) && (pos <= A - 1);
            exp_addr = acc_addr;
            exp_dato = acc_wdat;
        end
    end

    // ------------------------------------------------------------------------
    // Compare against the model every cycle; also gather activity counts.
    // ------------------------------------------------------------------------
    int            n_ce, n_oe, n_we, n_ack;
    logic [AW-1:0] last_addr;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outputs_zero",
                {mem_ce, mem_oe, mem_we, dma_ack, cpu_ovf, cpu_rdat, dma_rdat, mem_dato, mem_addr}, 64'd0);
        end else begin
            chk("mem_ce", mem_ce, exp_ce);
            chk("mem_oe", mem_oe, exp_oe);
            chk("mem_we", mem_we, exp_we);
            chk("mem_addr", mem_addr, exp_addr);
            chk("mem_dato", mem_dato, exp_dato);
            chk("dma_ack", dma_ack, exp_ack);
            chk("cpu_rdat", cpu_rdat, exp_cpu_rdat);
            chk("dma_rdat", dma_rdat, exp_dma_rdat);
            chk("cpu_ovf", cpu_ovf, exp_ovf);
            if (mem_ce)  begin n_ce++; last_addr = mem_addr; end
            if (mem_oe)  n_oe++;
            if (mem_we)  n_we++;
            if (dma_ack) n_ack++;
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic clr_mon();
        @(posedge clk);
        n_ce = 0; n_oe = 0; n_we = 0; n_ack = 0;
    endtask

    task automatic settle();
        repeat (12) @(negedge clk);
    endtask

    task automatic wait_ack(input string name);
        int i = 0;
        while (!dma_ack && i < 40) begin
            @(negedge clk);
            i++;
        end
        chk(name, dma_ack, 1'b1);
    endtask

    task automatic wait_ce(input string name);
        int i = 0;
        while (!mem_ce && i < 40) begin
            @(negedge clk);
            i++;
        end
        chk(name, mem_ce, 1'b1);
    endtask

    task automatic cpu_cycle(input logic [AW-1:0] a, input logic w, input logic [7:0] d);
        @(negedge clk);
        cpu_addr = a; cpu_we = w; cpu_wdat = d; cpu_req = 1; m2 = 1;
        repeat (4) @(negedge clk);
        m2 = 0; cpu_req = 0;
    endtask

    task automatic dma_xfer(input logic [AW-1:0] a, input logic w, input logic [7:0] d);
        @(negedge clk);
        dma_addr = a; dma_we = w; dma_wdat = d; dma_req = 1;
        wait_ack("dma_ack_seen");
        dma_req = 0;
    endtask

    // ------------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------------
    initial begin
        int g;
        rst_n = 0;
        repeat (3) @(negedge clk);
        chk("reset_ovf", cpu_ovf, 1'b0);
        chk("reset_ce", mem_ce, 1'b0);
        rst_n = 1;
        settle();

        // CPU read of address 0 returns 0x5A
        clr_mon();
        cpu_cycle(23'h000000, 1'b0, 8'h00);
        settle();
        chk("cpu_read_data", cpu_rdat, 8'h5A);
        chk("cpu_read_ce_cycles", n_ce, 4);
        chk("cpu_read_oe_cycles", n_oe, 4);
        chk("cpu_read_we_cycles", n_we, 0);

        // DMA write 0xC3 to 0x000123
        clr_mon();
        dma_xfer(23'h000123, 1'b1, 8'hC3);
        settle();
        chk("dma_write_we_cycles", n_we, 2);
        chk("dma_write_oe_cycles", n_oe, 0);
        chk("dma_write_ack_count", n_ack, 1);
        chk("dma_write_ce_cycles", n_ce, 4);

        // DMA read from the upper byte lane
        dma_xfer(23'h400055, 1'b0, 8'h00);
        settle();
        chk("dma_read_data", dma_rdat, 8'h0F);

        // CPU write
        cpu_cycle(23'h4A0010, 1'b1, 8'h77);
        settle();
        chk("cpu_write_addr", last_addr, 23'h4A0010);
        chk("cpu_write_data", mem_dato, 8'h77);

        // CPU pending and DMA request in the same IDLE cycle
        @(negedge clk);
        cpu_addr = 23'h000200; cpu_we = 0; cpu_req = 1; m2 = 1;
        repeat (3) @(negedge clk);
        dma_addr = 23'h000300; dma_we = 0; dma_req = 1;
        g = cyc;
        wait_ack("arb_ack_seen");
        chk("arb_grant_to_ack", cyc - g, 11);
        dma_req = 0; m2 = 0; cpu_req = 0;
        settle();
        chk("arb_cpu_data", cpu_rdat, hashf(23'h000200));

        // M2 rises during a DMA access
        @(negedge clk);
        dma_addr = 23'h000050; dma_we = 0; dma_req = 1;
        wait_ce("dma_start_seen");
        cpu_addr = 23'h000060; cpu_we = 0; cpu_req = 1; m2 = 1;
        wait_ack("dma_ack_during_cpu");
        dma_req = 0;
        repeat (3) @(negedge clk);
        m2 = 0; cpu_req = 0;
        settle();
        chk("no_overflow", cpu_ovf, 1'b0);
        chk("cpu_after_dma_addr", last_addr, 23'h000060);

        // Two CPU requests while the DMA access is running
        @(negedge clk);
        dma_addr = 23'h000070; dma_we = 0; dma_req = 1;
        wait_ce("dma2_start_seen");
        cpu_addr = 23'h000111; cpu_we = 0; cpu_req = 1; m2 = 1;
        @(negedge clk); m2 = 0;
        @(negedge clk); m2 = 1;
        @(negedge clk); m2 = 0; cpu_addr = 23'h000222;
        wait_ack("dma2_ack_seen");
        dma_req = 0;
        repeat (2) @(negedge clk);
        cpu_req = 0;
        settle();
        chk("overflow_set", cpu_ovf, 1'b1);
        chk("overflow_second_addr", last_addr, 23'h000222);
        chk("overflow_second_data", cpu_rdat, hashf(23'h000222));

        // Reset during DMA access cycle 2, request held across reset
        clr_mon();
        @(negedge clk);
        dma_addr = 23'h000777; dma_we = 1; dma_wdat = 8'h11; dma_req = 1;
        wait_ce("dma3_start_seen");
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("abort_strobes_low", {mem_ce, mem_oe, mem_we}, 3'b000);
        chk("abort_no_ack", dma_ack, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        wait_ack("restart_ack_seen");
        dma_req = 0;
        settle();
        chk("restart_single_ack", n_ack, 1);
        chk("restart_ovf_cleared", cpu_ovf, 1'b0);
        chk("restart_addr", mem_addr, 23'h000777);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/prg_mem_arb.md
PRG_MEM_ARB -- requirements
Module: prg_mem_arb

Interface
REQ-001 Parameter ACC_CYC, default 4: clk cycles per memory access; legal range 3..8.
REQ-002 Parameter ADDR_W, default 23: memory address width; bit ADDR_W-1 is the byte-lane select.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  system clock; all state advances on the rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 m2  in  1  cartridge M2, asynchronous to clk.
REQ-007 cpu_req  in  1  CPU cycle targets PRG; sampled on the synchronized m2 rise.
REQ-008 cpu_addr  in  ADDR_W; cpu_we  in  1; cpu_wdat  in  8  CPU access attributes; stable while m2 is high.
REQ-009 cpu_rdat  out  8  last CPU read data; holds until the next CPU read completes.
REQ-010 dma_req  in  1  MCU DMA request, level.
REQ-011 dma_addr  in  ADDR_W; dma_we  in  1; dma_wdat  in  8  DMA access attributes; held until dma_ack.
REQ-012 dma_ack  out  1  one-cycle pulse when a DMA access completes.
REQ-013 dma_rdat  out  8  DMA read data; valid from the dma_ack cycle.
REQ-014 cpu_ovf  out  1  sticky flag: a CPU request was lost.
REQ-015 mem_addr  out  ADDR_W; mem_dato  out  8  memory address and write data.
REQ-016 mem_dati  in  8  memory read data.
REQ-017 mem_ce, mem_oe, mem_we  out  1 each  active-high strobes, registered outputs.

Function
REQ-018 m2 SHALL pass through a 2-FF synchronizer; a rise edge is the synchronized value at 1 and the previous value at 0.
REQ-019 A rise edge with cpu_req=1 SHALL set cpu_pend and latch cpu_addr, cpu_we and cpu_wdat.
REQ-020 If a rise edge with cpu_req=1 occurs while cpu_pend=1 and the CPU access has not started: cpu_ovf SHALL set; the new request SHALL replace the old one.
REQ-021 FSM states: IDLE, CPU, DMA, RECOV.
- IDLE to CPU when cpu_pend=1.
- Otherwise IDLE to DMA when dma_req=1.
- CPU or DMA to RECOV after ACC_CYC cycles.
- RECOV to IDLE after 1 cycle.
REQ-022 When cpu_pend and dma_req are active in the same cycle, CPU SHALL win; an in-progress DMA access SHALL never be aborted.
REQ-023 Entering DMA SHALL latch dma_addr, dma_we and dma_wdat.
REQ-024 During CPU and DMA, mem_addr and mem_dato SHALL come from the latched attributes; mem_ce SHALL be 1 for all ACC_CYC cycles.
REQ-025 Read accesses: mem_oe=1 for all ACC_CYC cycles.
REQ-026 Write accesses: mem_we=1 on access cycles 2..ACC_CYC-1 only (1-cycle setup, 1-cycle hold); mem_oe=0.
REQ-027 On the last access cycle, read data SHALL be captured from mem_dati into cpu_rdat or dma_rdat; for DMA accesses dma_ack SHALL assert in the following cycle.
REQ-028 cpu_pend SHALL clear when its access enters CPU.
REQ-029 In RECOV and IDLE all strobes SHALL be 0; mem_addr and mem_dato hold their last values.
REQ-030 If dma_req is still 1 in the cycle after dma_ack, it SHALL be treated as a new request.
REQ-031 Worst-case latency from the synchronized m2 rise to CPU data valid: 1 (edge) + up to ACC_CYC+1 (DMA drain + RECOV) + ACC_CYC.

Reset
REQ-032 While rst_n=0:
- all outputs SHALL be 0;
- FSM SHALL be in IDLE;
- cpu_pend, cpu_ovf and the synchronizer SHALL be 0.
REQ-033 Reset asserted mid-access SHALL drop mem_ce, mem_oe and mem_we asynchronously; no dma_ack SHALL be issued for the aborted access.

Verification
REQ-034 CPU read, ACC_CYC=4, mem_dati=0x5A: m2 rise with cpu_req=1 -> mem_ce/oe high for 4 cycles, cpu_rdat=0x5A, then 1 RECOV cycle.
REQ-035 DMA write addr 0x000123, data 0xC3: mem_we high on cycles 2-3 only; dma_ack pulses once; mem_oe stays 0.
REQ-036 cpu_pend and dma_req both asserted in IDLE: CPU access first, then RECOV, then DMA; dma_ack arrives 11 cycles after the grant cycle.
REQ-037 m2 rises during a DMA access: the DMA access completes untouched; the CPU access starts right after RECOV; cpu_ovf stays 0.
REQ-038 Two m2 rises with cpu_req=1 while the FSM is held in DMA: cpu_ovf=1; the second address is the one accessed.
REQ-039 rst_n low on DMA access cycle 2: strobes drop at once with no dma_ack; after release, FSM in IDLE; a held dma_req restarts the access.
